chan_scan_mux: RTL

Parametrised N-channel, WIDTH-bit registered multiplexer. It generalises the 4:1 switch mux and adds an auto-scan mode that steps through the channels on a programmable dwell time. The output, the current channel index and a channel-change strobe are all registered. It sits between the board switch/sensor inputs and the display or UART logic, which needs either a fixed channel or a rotating view of all channels.

---
 rtl/chan_scan_mux_if.sv | 22 ++
 rtl/chan_scan_mux.sv | 71 +++++++
 2 files changed

// File: rtl/chan_scan_mux_if.sv
// chan_scan_mux_if: channel data, select/mode/hold controls and registered mux outputs; CHAN_MASK_EN adds ch_mask
interface chan_scan_mux_if #(
  parameter int WIDTH  = 2,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_CH*WIDTH-1:0] din;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic                    hold;
  logic [WIDTH-1:0]        dout;
  logic [SEL_W-1:0]        ch;
  logic                    ch_change;
`ifdef CHAN_MASK_EN
  logic [NUM_CH-1:0]       ch_mask;
  modport master (output din, sel, mode, hold, ch_mask, input dout, ch, ch_change);
  modport slave  (input din, sel, mode, hold, ch_mask, output dout, ch, ch_change);
`else
  modport master (output din, sel, mode, hold, input dout, ch, ch_change);
  modport slave  (input din, sel, mode, hold, output dout, ch, ch_change);
`endif
endinterface

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel registered mux with manual select and dwell-timed auto-scan; CHAN_MASK_EN adds a channel enable mask
module chan_scan_mux #(
  parameter int WIDTH  = 2,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 4
) (
  input logic            clk,
  input logic            rst,
  chan_scan_mux_if.slave bus
);
  localparam int CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);
  typedef enum logic {MANUAL, SCAN} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] ch_q, ch_d, adv;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             chg_q, chg_d, sel_ok, found;
  logic [NUM_CH-1:0] en;
`ifdef CHAN_MASK_EN
  assign en = bus.ch_mask;
`else
  assign en = '1;
`endif
  assign sel_ok        = (int'(bus.sel) < NUM_CH) && en[bus.sel];
  assign bus.dout      = dout_q;
  assign bus.ch        = ch_q;
  assign bus.ch_change = chg_q;
  // Next enabled channel above ch_q with wraparound; stays put when no other channel is enabled
  always_comb begin
    adv   = ch_q;
    found = 1'b0;
    for (int k = 1; k < NUM_CH; k++) begin
      if (!found && en[(int'(ch_q) + k) % NUM_CH]) begin
        adv   = SEL_W'((int'(ch_q) + k) % NUM_CH);
        found = 1'b1;
      end
    end
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MANUAL;
      ch_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      chg_q   <= chg_d;
    end
  end
  // Mode is sampled every edge and always wins over hold or dwell expiry
  always_comb state_d = bus.mode ? SCAN : MANUAL;
  // Channel/counter update; entering scan keeps ch and clears the counter
  always_comb begin
    cnt_d = '0;
    ch_d  = ch_q;
    if (!bus.mode) ch_d = sel_ok ? bus.sel : ch_q;
    else if (state_q == SCAN) begin
      cnt_d = bus.hold ? cnt_q : (cnt_q == LAST ? '0 : cnt_q + 1'b1);
      ch_d  = (!bus.hold && cnt_q == LAST) ? adv : ch_q;
    end
    dout_d = bus.din[ch_d*WIDTH +: WIDTH];
    chg_d  = ch_d != ch_q;
  end
endmodule
